// File: rtl/credit_input_buffer_if.sv
// Receive-side credit link bundle between an upstream router output and a
// credit_input_buffer. The master side drives the flit and the pop request;
// the slave side (the buffer) returns head flit, occupancy, credit and error.
//
// Handshake semantics: valid_i marks a flit that upstream sends only while it
// holds a credit, so there is no ready signal; rd_i pops the head flit in the
// cycle it is high when valid_o is high; each accepted pop returns exactly one
// credit_o pulse on the following cycle.
interface credit_input_buffer_if #(
    parameter int DATA_W = 34,
    parameter int CNT_W  = 3
);
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              rd_i;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              credit_o;
    logic [CNT_W-1:0]  count_o;
    logic              overflow_o;

    modport master (
        output valid_i, data_i, rd_i,
        input  valid_o, data_o, credit_o, count_o, overflow_o
    );

    modport slave (
        input  valid_i, data_i, rd_i,
        output valid_o, data_o, credit_o, count_o, overflow_o
    );
endinterface

// File: rtl/credit_input_buffer.sv
// Router input-port buffer on the receive end of a credit link. Flits are held
// in a DEPTH-entry circular FIFO presented first-word-fall-through, and every
// dequeued flit returns one credit pulse upstream one cycle after the pop, so
// credits handed back can never outrun the slots actually freed.
module credit_input_buffer #(
    parameter int DATA_W = 34,
    parameter int DEPTH  = 5,
    parameter int CNT_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    credit_input_buffer_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LP_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_credit;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_overflow;

    // A full buffer still accepts a write when the head leaves in the same cycle.
    always_comb begin
        w_full     = (r_count == LP_DEPTH);
        w_empty    = (r_count == '0);
        w_pop      = bus.rd_i & ~w_empty;
        w_push     = bus.valid_i & (~w_full | w_pop);
        w_overflow = bus.valid_i & w_full & ~w_pop;
    end

    // Pointers, occupancy, credit return and sticky overflow; reset drops all flits silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_credit <= w_pop;
            if (w_overflow) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Flit storage is never cleared; stale entries are hidden behind valid_o.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= bus.data_i;
        end
    end

    assign bus.valid_o    = ~w_empty;
    assign bus.data_o     = r_mem[r_rd_ptr];
    assign bus.credit_o   = r_credit;
    assign bus.count_o    = r_count;
    assign bus.overflow_o = r_overflow;
endmodule

// File: tb/tb_credit_input_buffer.sv
// Directed bench for credit_input_buffer: reset/idle, fill, drain with credits,
// wrap under simultaneous push/pop, overflow drop vs. full-with-pop accept,
// empty pop and mid-operation reset.
module tb_credit_input_buffer;
    localparam int DATA_W = 34;
    localparam int DEPTH  = 5;
    localparam int CNT_W  = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   n_credits;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] head;

    credit_input_buffer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    credit_input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge; sample and drive 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"},  64'(bus.count_o), 64'd0);
        chk({tag, "_valid"},  64'(bus.valid_o), 64'd0);
        chk({tag, "_credit"}, 64'(bus.credit_o), 64'd0);
    endtask

    // driver: write one flit with no pop
    task automatic push_only(input logic [DATA_W-1:0] d);
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        bus.rd_i    = 1'b0;
        tick();
        exp_q.push_back(d);
        bus.valid_i = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_credits = 0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.rd_i    = 1'b0;

        // reset then idle
        rst = 1'b1;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_ovf", 64'(bus.overflow_o), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle("idle");
            chk("idle_ovf", 64'(bus.overflow_o), 64'd0);
        end

        // fill to DEPTH with 0x01..0x05
        for (int i = 1; i <= DEPTH; i++) begin
            bus.valid_i = 1'b1;
            bus.data_i  = DATA_W'(i);
            tick();
            exp_q.push_back(DATA_W'(i));
            chk("fill_count",  64'(bus.count_o), 64'(i));
            chk("fill_valid",  64'(bus.valid_o), 64'd1);
            chk("fill_head",   64'(bus.data_o), 64'h01);
            chk("fill_credit", 64'(bus.credit_o), 64'd0);
            chk("fill_ovf",    64'(bus.overflow_o), 64'd0);
        end
        bus.valid_i = 1'b0;

        // drain with credits
        for (int i = 1; i <= DEPTH; i++) begin
            head = exp_q.pop_front();
            chk("drain_head", 64'(bus.data_o), 64'(head));
            bus.rd_i = 1'b1;
            tick();
            chk("drain_credit", 64'(bus.credit_o), 64'd1);
            chk("drain_count",  64'(bus.count_o), 64'(DEPTH - i));
        end
        bus.rd_i = 1'b0;
        tick();
        chk_idle("drained");

        // wrap with simultaneous push/pop at count=3
        push_only(34'h20);
        push_only(34'h21);
        push_only(34'h22);
        chk("pp_pre_count", 64'(bus.count_o), 64'd3);
        n_credits = 0;
        for (int i = 0; i < 8; i++) begin
            head = exp_q.pop_front();
            chk("pp_head", 64'(bus.data_o), 64'(head));
            bus.valid_i = 1'b1;
            bus.data_i  = DATA_W'(8'h10 + i);
            bus.rd_i    = 1'b1;
            tick();
            exp_q.push_back(DATA_W'(8'h10 + i));
            if (bus.credit_o === 1'b1) n_credits++;
            chk("pp_count", 64'(bus.count_o), 64'd3);
        end
        bus.valid_i = 1'b0;
        bus.rd_i    = 1'b0;
        chk("pp_credits", 64'(n_credits), 64'd8);
        tick();
        chk("pp_credit_end", 64'(bus.credit_o), 64'd0);
        chk("pp_head_after", 64'(bus.data_o), 64'h15);

        // overflow: full, write without pop is dropped and sets sticky flag
        push_only(34'h30);
        push_only(34'h31);
        chk("ovf_pre_count", 64'(bus.count_o), 64'd5);
        bus.valid_i = 1'b1;
        bus.data_i  = 34'hAA;
        tick();
        bus.valid_i = 1'b0;
        chk("ovf_count", 64'(bus.count_o), 64'd5);
        chk("ovf_flag",  64'(bus.overflow_o), 64'd1);
        tick();
        tick();
        chk("ovf_sticky", 64'(bus.overflow_o), 64'd1);
        chk("ovf_head",   64'(bus.data_o), 64'h15);

        // reset while full with rd_i high: nothing popped, no credit
        rst      = 1'b1;
        bus.rd_i = 1'b1;
        tick();
        chk_idle("rst_full");
        chk("rst_full_ovf", 64'(bus.overflow_o), 64'd0);
        rst      = 1'b0;
        bus.rd_i = 1'b0;
        exp_q.delete();

        // full with pop in the same cycle accepts the write
        for (int i = 1; i <= DEPTH; i++) push_only(DATA_W'(8'h40 + i));
        bus.valid_i = 1'b1;
        bus.data_i  = 34'hAA;
        bus.rd_i    = 1'b1;
        tick();
        void'(exp_q.pop_front());
        exp_q.push_back(34'hAA);
        bus.valid_i = 1'b0;
        bus.rd_i    = 1'b0;
        chk("fullpp_count",  64'(bus.count_o), 64'd5);
        chk("fullpp_ovf",    64'(bus.overflow_o), 64'd0);
        chk("fullpp_credit", 64'(bus.credit_o), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            head = exp_q.pop_front();
            chk("fullpp_drain", 64'(bus.data_o), 64'(head));
            bus.rd_i = 1'b1;
            tick();
        end
        chk("fullpp_last_credit", 64'(bus.credit_o), 64'd1);
        chk("fullpp_empty", 64'(bus.count_o), 64'd0);

        // pop on empty is ignored
        tick();
        chk_idle("empty_pop1");
        tick();
        chk_idle("empty_pop2");
        bus.rd_i = 1'b0;

        // mid-operation reset at count=3 with rd_i high
        push_only(34'h51);
        push_only(34'h52);
        push_only(34'h53);
        chk("mid_pre_count", 64'(bus.count_o), 64'd3);
        rst      = 1'b1;
        bus.rd_i = 1'b1;
        tick();
        chk_idle("mid_rst");
        rst      = 1'b0;
        bus.rd_i = 1'b0;
        exp_q.delete();
        tick();
        chk_idle("mid_rst_after");

        // buffer usable after reset: new flit appears next cycle
        push_only(34'h3_0000_0001);
        chk("post_head",  64'(bus.data_o), 64'h3_0000_0001);
        chk("post_count", 64'(bus.count_o), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // hard time limit in case the sequence stalls
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/credit_input_buffer.md
Name: credit_input_buffer

Overview:
- Receive-side end of the credit-based link between routers.
- Sits at each router input port. Stores incoming flits in a DEPTH-entry FIFO and presents them first-word-fall-through to the router crossbar/allocator.
- Returns one credit pulse to the upstream sender per flit dequeued.
- Upstream credit counter resets to DEPTH credits; this block guarantees credits issued never exceed slots freed.

Parameters:
- DATA_W, 34, flit width in bits (payload + head/tail flags, opaque to this block)
- DEPTH, 5, buffer entries; must equal upstream credit counter reset value; legal range 2..7
- CNT_W, 3, width of occupancy count; must hold 0..DEPTH

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  upstream flit present this cycle (sent only when upstream holds a credit)
- data_i  in  DATA_W  upstream flit
- rd_i  in  1  downstream pops head flit this cycle
- valid_o  out  1  head flit available (buffer non-empty)
- data_o  out  DATA_W  head flit, FWFT
- credit_o  out  1  one-cycle credit return pulse to upstream counter (its up input)
- count_o  out  CNT_W  current occupancy
- overflow_o  out  1  sticky error: write attempted with no free slot

Behaviour:
- Reset (rst high at clock edge) clears the following; reset mid-operation discards all stored flits with no credits returned:
  - write pointer and read pointer to 0
  - count_o to 0
  - credit_o to 0
  - overflow_o to 0
- Reset has no effect on memory contents; data_o is don't-care while valid_o=0.
- valid_o = (count != 0), combinational from count.
- data_o = mem[rd_ptr], combinational read.
- Storage: DEPTH x DATA_W register array.
- Pointers: 0..DEPTH-1, each incrementing by 1. Explicit wrap DEPTH-1 -> 0 (DEPTH need not be a power of 2).
- push = valid_i & (count < DEPTH | pop)
  - A write to a full buffer is accepted when the pop occurs in the same cycle.
- pop = rd_i & (count != 0)
  - rd_i on an empty buffer is ignored: no pointer change, no credit.
  - No bypass: a flit written this cycle is visible on data_o no earlier than the next cycle.
- Count update:
  - push & ~pop: count+1
  - pop & ~push: count-1
  - both or neither: count unchanged
- Overflow: valid_i & (count == DEPTH) & ~pop
  - Flit dropped; pointers/count unchanged.
  - overflow_o set to 1 on the next edge and held until rst.
- Credit: credit_o registered, credit_o <= pop.
  - Credit latency: exactly 1 cycle after the pop edge.
  - Back-to-back pops give back-to-back credit pulses.
  - Number of credit pulses always equals the number of successful pops.
- Simultaneous push and pop:
  - Write to mem[wr_ptr]; both pointers advance; count unchanged; credit_o pulses next cycle.
- Invariant: count_o + (credits held upstream) + (credit_o in flight) = DEPTH whenever upstream obeys credits.
- Throughput: one push and one pop per cycle sustained.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then inputs 0 -> count_o=0, valid_o=0, credit_o=0, overflow_o=0 for 10 cycles.
- Fill to DEPTH: write 0x01..0x05 on consecutive cycles, rd_i=0 -> count_o steps 1..5; valid_o=1 from cycle after first write; data_o=0x01; no credit_o; overflow_o=0.
- Drain with credits: from full, rd_i=1 for 5 cycles -> data_o shows 0x01..0x05 in order; credit_o high on the 5 cycles each one cycle after its pop; count_o reaches 0; valid_o=0 after.
- Wrap and simultaneous push/pop: with count=3, push and pop together for 8 cycles (data 0x10..0x17) -> count_o stays 3; order preserved across pointer wrap at 4->0; 8 credit pulses.
- Overflow: at count=5, valid_i=1 with data 0xAA and rd_i=0 -> flit dropped; count_o=5; overflow_o=1 next cycle and sticky. Same stimulus with rd_i=1 -> accepted, overflow_o stays 0.
- Empty pop and mid-operation reset: rd_i=1 at count=0 -> no credit_o, count stays 0. At count=3, assert rst -> next cycle count_o=0, valid_o=0, credit_o=0 even if rd_i=1 during reset.
